// File: rtl/uart_tx_fifo_drain.sv
// Drains an upstream byte FIFO onto a UART line: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state, pop strobe and completion pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_rd   = 1'b0;
    tx_done   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          tx_done = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Line level is registered from the next state so tx never glitches on decode.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: table vectors, corner sequences, random bytes.
module tb_uart_tx_fifo_drain;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;
  localparam int RD_BOUND = 20;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_drain #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         checks;
  int         failures;
  int         cyc;
  logic       s_tx, s_busy, s_done, s_rd;
  logic [7:0] fifo_q[$];
  bit         garbage;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;  // {stop, d7..d0, start}
    logic       par;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    if (garbage) begin
      fifo_empty = 1'($urandom_range(0, 1));
      fifo_rdata = 8'($urandom);
    end else begin
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_q.size() != 0) fifo_rdata = fifo_q[0];
      else fifo_rdata = 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  // One clock: sample outputs mid-cycle, then after the edge retire any pop and update inputs.
  task automatic step();
    @(negedge clk);
    s_tx   = tx;
    s_busy = tx_busy;
    s_done = tx_done;
    s_rd   = fifo_rd;
    cyc++;
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  // Reference frame computed straight from the line format.
  function automatic logic [NB-1:0] model_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic wait_rd(input string tag, output int at);
    at = -1;
    for (int i = 0; i < RD_BOUND && at < 0; i++) begin
      step();
      if (s_rd) begin
        at = cyc;
        check($sformatf("%s idle tx", tag), s_tx, 1);
        check($sformatf("%s idle busy", tag), s_busy, 0);
      end
    end
    check($sformatf("%s fifo_rd seen", tag), (at >= 0), 1);
  endtask

  task automatic frame_check(input logic [7:0] b, input logic [NB-1:0] exp, input string tag,
                             input bit noise);
    logic [NB-1:0] obs;
    int done_n, done_at, busy_lo, rd_n, p;
    obs = '0; done_n = 0; done_at = -1; busy_lo = 0; rd_n = 0;
    for (int k = 1; k <= FRAME; k++) begin
      garbage = noise && (k < FRAME);
      step();
      p = (k - 1) / DIV;
      if ((k - 1) % DIV == 0) obs[p] = s_tx;
      else if (s_tx !== exp[p]) obs[p] = s_tx;
      if (s_done === 1'b1) begin
        done_n++;
        done_at = k;
      end
      if (s_busy !== 1'b1) busy_lo++;
      if (s_rd !== 1'b0) rd_n++;
    end
    garbage = 1'b0;
    for (int q = 0; q < NB; q++) check($sformatf("%s tx bit %0d", tag, q), obs[q], exp[q]);
    check($sformatf("%s decoded byte", tag), obs[8:1], b);
    check($sformatf("%s tx_done count", tag), done_n, 1);
    check($sformatf("%s tx_done cycle", tag), done_at, FRAME);
    check($sformatf("%s busy low cycles", tag), busy_lo, 0);
    check($sformatf("%s fifo_rd in frame", tag), rd_n, 0);
  endtask

  initial begin : main
    int at, prev_at, bad_tx, bad_rd, bad_busy, n, gap;
    logic [NB-1:0] e;
    logic [7:0] b;
    logic [7:0] bs[$];

    checks = 0; failures = 0; cyc = 0; garbage = 1'b0;
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[5] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[6] = '{8'h01, 10'b1_00000001_0, 1'b1};
    vecs[7] = '{8'h80, 10'b1_10000000_0, 1'b1};

    rst = 1'b0;
    drive_fifo();
    #1 rst = 1'b1;
    #2;
    check("reset tx", tx, 1);
    check("reset busy", tx_busy, 0);
    check("reset fifo_rd", fifo_rd, 0);
    check("reset done", tx_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Empty FIFO for 100 cycles: line stays idle.
    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (s_tx !== 1'b1) bad_tx++;
      if (s_rd !== 1'b0) bad_rd++;
      if (s_busy !== 1'b0) bad_busy++;
    end
    check("idle tx low cycles", bad_tx, 0);
    check("idle fifo_rd cycles", bad_rd, 0);
    check("idle busy cycles", bad_busy, 0);

    // Table vectors, one byte at a time.
    for (int i = 0; i < 8; i++) begin
`ifdef UART_TX_PARITY_EN
      e = {1'b1, vecs[i].par, vecs[i].bits[8:0]};
`else
      e = vecs[i].bits;
`endif
      push(vecs[i].data);
      wait_rd($sformatf("vec%0d", i), at);
      frame_check(vecs[i].data, e, $sformatf("vec%0d", i), 1'b0);
    end

    // Three bytes queued together go out back to back.
    for (int i = 1; i <= 3; i++) fifo_q.push_back(vecs[i].data);
    drive_fifo();
    prev_at = -1;
    for (int i = 1; i <= 3; i++) begin
`ifdef UART_TX_PARITY_EN
      e = {1'b1, vecs[i].par, vecs[i].bits[8:0]};
`else
      e = vecs[i].bits;
`endif
      wait_rd($sformatf("b2b%0d", i), at);
      if (prev_at >= 0) check($sformatf("b2b%0d rd spacing", i), at - prev_at, FRAME + 1);
      prev_at = at;
      frame_check(vecs[i].data, e, $sformatf("b2b%0d", i), 1'b0);
    end

    // FIFO inputs thrash while a frame is in flight.
    push(8'h96);
    wait_rd("noise", at);
    frame_check(8'h96, model_frame(8'h96), "noise", 1'b1);
    bad_rd = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_rd !== 1'b0) bad_rd++;
    end
    check("noise post rd", bad_rd, 0);

    // Reset in cycle 45 of a frame.
    push(8'h00);
    wait_rd("midrst", at);
    for (int k = 1; k <= 44; k++) step();
    check("midrst tx before", tx, 0);
    rst = 1'b1;
    #1;
    check("midrst tx", tx, 1);
    check("midrst busy", tx_busy, 0);
    check("midrst fifo_rd", fifo_rd, 0);
    check("midrst done", tx_done, 0);
    bad_tx = 0; bad_rd = 0; bad_busy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_tx !== 1'b1) bad_tx++;
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_tx !== 1'b1) bad_tx++;
      if (s_rd !== 1'b0) bad_rd++;
      if (s_busy !== 1'b0) bad_busy++;
    end
    check("midrst tx low after", bad_tx, 0);
    check("midrst fifo_rd after", bad_rd, 0);
    check("midrst busy after", bad_busy, 0);

    // Random bursts of 1..3 bytes with random idle gaps.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 3);
      bs.delete();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        bs.push_back(b);
        fifo_q.push_back(b);
      end
      drive_fifo();
      prev_at = -1;
      for (int j = 0; j < n; j++) begin
        wait_rd($sformatf("rnd%0d.%0d", it, j), at);
        if (prev_at >= 0) check($sformatf("rnd%0d.%0d rd spacing", it, j), at - prev_at, FRAME + 1);
        prev_at = at;
        frame_check(bs[j], model_frame(bs[j]), $sformatf("rnd%0d.%0d", it, j), 1'b0);
      end
      gap = $urandom_range(1, 12);
      bad_tx = 0;
      for (int g = 0; g < gap; g++) begin
        step();
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_rd !== 1'b0) bad_tx++;
      end
      check($sformatf("rnd%0d idle gap", it), bad_tx, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
